// File: rtl/me_full_search_et_if.sv
// Handshake and row-streaming bus between the full-search motion-estimation
// engine and its surroundings: start/result handshake, CPR/SPR row fetch and
// the best-vector report.
interface me_full_search_et_if #(
  parameter int MACRO_DIM  = 16,
  parameter int SEARCH_DIM = 32
);
  localparam int RANGE = SEARCH_DIM - MACRO_DIM + 1;
  localparam int SADW  = $clog2(MACRO_DIM * MACRO_DIM * 255 + 1);
  localparam int MVW   = $clog2(RANGE);
  localparam int CNTW  = $clog2(RANGE * RANGE + 1);
  localparam int CRW   = $clog2(MACRO_DIM);
  localparam int SRW   = $clog2(SEARCH_DIM);

  logic                   start;
  logic                   readyi;
  logic                   et_en;
  logic [SADW-1:0]        sad_thresh;
  logic                   rd_en;
  logic [CRW-1:0]         cpr_row;
  logic [SRW-1:0]         spr_row;
  logic [MVW-1:0]         spr_off;
  logic [MACRO_DIM*8-1:0] pixel_cpr_in;
  logic [MACRO_DIM*8-1:0] pixel_spr_in;
  logic                   valido;
  logic                   readyo;
  logic [MVW-1:0]         mv_x;
  logic [MVW-1:0]         mv_y;
  logic [SADW-1:0]        min_sad;
  logic                   early_stop;
  logic [CNTW-1:0]        cand_cnt;

  // Requester / buffer side
  modport master (
    output start, et_en, sad_thresh, pixel_cpr_in, pixel_spr_in, readyo,
    input  readyi, rd_en, cpr_row, spr_row, spr_off, valido,
           mv_x, mv_y, min_sad, early_stop, cand_cnt
  );

  // Engine side
  modport slave (
    input  start, et_en, sad_thresh, pixel_cpr_in, pixel_spr_in, readyo,
    output readyi, rd_en, cpr_row, spr_row, spr_off, valido,
           mv_x, mv_y, min_sad, early_stop, cand_cnt
  );
endinterface

// File: rtl/me_full_search_et.sv
// Full-search integer motion estimation. Every candidate position of the
// current macroblock inside the search window is scored by SAD, one row pair
// per cycle. Candidates can be abandoned early once their partial SAD can no
// longer win, and the whole search can stop once a good-enough match is found.
module me_full_search_et #(
  parameter int MACRO_DIM  = 16,
  parameter int SEARCH_DIM = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  me_full_search_et_if.slave bus
);
  localparam int RANGE = SEARCH_DIM - MACRO_DIM + 1;
  localparam int SADW  = $clog2(MACRO_DIM * MACRO_DIM * 255 + 1);
  localparam int MVW   = $clog2(RANGE);
  localparam int CNTW  = $clog2(RANGE * RANGE + 1);
  localparam int CRW   = $clog2(MACRO_DIM);
  localparam int SRW   = $clog2(SEARCH_DIM);

  typedef enum logic [1:0] {IDLE, FILL, ACC, DONE} state_t;

  state_t         state;
  logic [MVW-1:0] cand_x;
  logic [MVW-1:0] cand_y;
  logic [CRW-1:0] row;
  logic [SADW-1:0] acc;
  logic [SADW-1:0] best_min;
  logic            best_valid;
  logic            et_q;
  logic [SADW-1:0] thresh_q;

  logic [SADW-1:0] row_sad;
  logic [SADW-1:0] acc_new;
  logic            last_row;
  logic            last_cand;
  logic            abort_hit;
  logic            cand_end;
  logic            take_best;
  logic            stop_hit;
  logic [MVW-1:0]  nxt_x;
  logic [MVW-1:0]  nxt_y;

  // Sum of absolute differences of the row pair currently on the pixel inputs
  always_comb begin
    row_sad = '0;
    for (int i = 0; i < MACRO_DIM; i++) begin
      if (bus.pixel_cpr_in[i*8 +: 8] >= bus.pixel_spr_in[i*8 +: 8])
        row_sad = row_sad + SADW'(bus.pixel_cpr_in[i*8 +: 8] - bus.pixel_spr_in[i*8 +: 8]);
      else
        row_sad = row_sad + SADW'(bus.pixel_spr_in[i*8 +: 8] - bus.pixel_cpr_in[i*8 +: 8]);
    end
  end

  // Candidate bookkeeping: running SAD, abort/update/stop decisions, raster successor
  always_comb begin
    acc_new   = (row == '0) ? row_sad : acc + row_sad;
    last_row  = (row == CRW'(MACRO_DIM - 1));
    last_cand = (cand_x == MVW'(RANGE - 1)) && (cand_y == MVW'(RANGE - 1));
    abort_hit = !last_row && et_q && best_valid && (acc_new >= best_min);
    cand_end  = last_row || abort_hit;
    take_best = last_row && (!best_valid || (acc_new < best_min));
    stop_hit  = take_best && (thresh_q != '0) && (acc_new <= thresh_q);
    if (cand_x == MVW'(RANGE - 1)) begin
      nxt_x = '0;
      nxt_y = cand_y + MVW'(1);
    end else begin
      nxt_x = cand_x + MVW'(1);
      nxt_y = cand_y;
    end
  end

  // Search sequencer with registered bus outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      bus.readyi     <= 1'b1;
      bus.valido     <= 1'b0;
      bus.rd_en      <= 1'b0;
      bus.cpr_row    <= '0;
      bus.spr_row    <= '0;
      bus.spr_off    <= '0;
      bus.mv_x       <= '0;
      bus.mv_y       <= '0;
      bus.min_sad    <= '1;
      bus.early_stop <= 1'b0;
      bus.cand_cnt   <= '0;
      cand_x         <= '0;
      cand_y         <= '0;
      row            <= '0;
      acc            <= '0;
      best_min       <= '1;
      best_valid     <= 1'b0;
      et_q           <= 1'b0;
      thresh_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state          <= FILL;
            bus.readyi     <= 1'b0;
            et_q           <= bus.et_en;
            thresh_q       <= bus.sad_thresh;
            best_valid     <= 1'b0;
            best_min       <= '1;
            bus.cand_cnt   <= '0;
            bus.early_stop <= 1'b0;
            cand_x         <= '0;
            cand_y         <= '0;
            bus.rd_en      <= 1'b1;
            bus.cpr_row    <= '0;
            bus.spr_row    <= '0;
            bus.spr_off    <= '0;
          end
        end
        FILL: begin
          state        <= ACC;
          row          <= '0;
          bus.cand_cnt <= bus.cand_cnt + CNTW'(1);
          bus.rd_en    <= 1'b1;
          bus.cpr_row  <= CRW'(1);
          bus.spr_row  <= SRW'(cand_y) + SRW'(1);
        end
        ACC: begin
          if (!cand_end) begin
            acc <= acc_new;
            row <= row + CRW'(1);
            if (row != CRW'(MACRO_DIM - 2)) begin
              bus.rd_en   <= 1'b1;
              bus.cpr_row <= row + CRW'(2);
              bus.spr_row <= SRW'(cand_y) + SRW'(row) + SRW'(2);
            end else begin
              bus.rd_en <= 1'b0;
            end
          end else begin
            if (take_best) begin
              best_valid  <= 1'b1;
              best_min    <= acc_new;
              bus.min_sad <= acc_new;
              bus.mv_x    <= cand_x;
              bus.mv_y    <= cand_y;
            end
            if (stop_hit) begin
              state          <= DONE;
              bus.early_stop <= 1'b1;
              bus.rd_en      <= 1'b0;
            end else if (last_cand) begin
              state     <= DONE;
              bus.rd_en <= 1'b0;
            end else begin
              state       <= FILL;
              cand_x      <= nxt_x;
              cand_y      <= nxt_y;
              bus.rd_en   <= 1'b1;
              bus.cpr_row <= '0;
              bus.spr_row <= SRW'(nxt_y);
              bus.spr_off <= nxt_x;
            end
          end
        end
        DONE: begin
          if (!bus.valido) begin
            bus.valido <= 1'b1;
          end else if (bus.readyo) begin
            bus.valido <= 1'b0;
            bus.readyi <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_me_full_search_et.sv
// Directed bench for the full-search ME engine with a 4x4 macroblock in an
// 8x8 window. A plain array model scores all candidates; a compare process
// checks the result bus against it on every cycle the result is valid.
module tb_me_full_search_et;
  localparam int M    = 4;
  localparam int S    = 8;
  localparam int R    = S - M + 1;
  localparam int SADW = $clog2(M * M * 255 + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  me_full_search_et_if #(.MACRO_DIM(M), .SEARCH_DIM(S)) bus ();

  me_full_search_et #(.MACRO_DIM(M), .SEARCH_DIM(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int cur [M][M];
  int win [S][S];

  int checks = 0;
  int errors = 0;
  logic expect_valid = 1'b0;
  int exp_mvx, exp_mvy, exp_sad, exp_es, exp_cnt, exp_lat;
  int lat;

  // Row buffers: one-cycle read latency, search row already column-aligned
  always @(posedge clk) begin
    if (bus.rd_en === 1'b1) begin
      for (int i = 0; i < M; i++) begin
        bus.pixel_cpr_in[i*8 +: 8] <= 8'(cur[bus.cpr_row][i]);
        bus.pixel_spr_in[i*8 +: 8] <= 8'(win[bus.spr_row][int'(bus.spr_off) + i]);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int rowSad(int x, int y, int r);
    int s = 0;
    for (int c = 0; c < M; c++) begin
      int d = cur[r][c] - win[y + r][x + c];
      s += (d < 0) ? -d : d;
    end
    return s;
  endfunction

  // Scores candidates in raster order following the search rules directly
  task automatic runModel(input logic et, input int th);
    int best = 0;
    bit best_ok = 0;
    bit stop = 0;
    int cyc = 0;
    exp_cnt = 0;
    exp_mvx = 0;
    exp_mvy = 0;
    for (int y = 0; y < R; y++) begin
      for (int x = 0; x < R; x++) begin
        if (!stop) begin
          int part = 0;
          bit aborted = 0;
          exp_cnt++;
          for (int r = 0; r < M; r++) begin
            if (!aborted) begin
              part += rowSad(x, y, r);
              if (r < M - 1 && et && best_ok && part >= best) begin
                aborted = 1;
                cyc += r + 2;
              end
            end
          end
          if (!aborted) begin
            cyc += M + 1;
            if (!best_ok || part < best) begin
              best_ok = 1;
              best = part;
              exp_mvx = x;
              exp_mvy = y;
              if (th != 0 && part <= th) stop = 1;
            end
          end
        end
      end
    end
    exp_sad = best;
    exp_es  = stop ? 1 : 0;
    exp_lat = cyc + 1;
  endtask

  // Result bus against the model while a result is presented
  always @(negedge clk) begin
    if (rst_n && expect_valid && bus.valido === 1'b1) begin
      checkOutput("mv_x", bus.mv_x, exp_mvx);
      checkOutput("mv_y", bus.mv_y, exp_mvy);
      checkOutput("min_sad", bus.min_sad, exp_sad);
      checkOutput("early_stop", bus.early_stop, exp_es);
      checkOutput("cand_cnt", bus.cand_cnt, exp_cnt);
      checkOutput("readyi_in_done", bus.readyi, 0);
    end
  end

  task automatic setupIdentity(input bit big_row0);
    for (int y = 0; y < S; y++)
      for (int x = 0; x < S; x++) win[y][x] = 0;
    for (int r = 0; r < M; r++)
      for (int c = 0; c < M; c++) begin
        cur[r][c] = (big_row0 && r == 0) ? 255 : 10 + 4 * r + c;
        win[2 + r][3 + c] = cur[r][c];
      end
  endtask

  task automatic setupUniform();
    for (int y = 0; y < S; y++)
      for (int x = 0; x < S; x++) win[y][x] = 7;
    for (int r = 0; r < M; r++)
      for (int c = 0; c < M; c++) cur[r][c] = 7;
  endtask

  task automatic setupThresh();
    for (int y = 0; y < S; y++)
      for (int x = 0; x < S; x++) win[y][x] = 0;
    for (int r = 0; r < M; r++)
      for (int c = 0; c < M; c++) begin
        cur[r][c] = 10 + 4 * r + c;
        win[r][1 + c] = cur[r][c];
      end
    win[0][1] += 1;
    win[1][2] += 1;
    win[3][4] += 1;
  endtask

  // One search: start, measure latency, hold the result for a while, accept
  task automatic applyStimulus(input logic et, input int th, input int hold);
    runModel(et, th);
    bus.et_en = et;
    bus.sad_thresh = SADW'(th);
    checkOutput("readyi_before_start", bus.readyi, 1);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    expect_valid = 1'b1;
    lat = 0;
    while (bus.valido !== 1'b1 && lat < 3000) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("latency", lat, exp_lat);
    for (int i = 0; i < hold; i++) begin
      bus.start = i[0];
      @(posedge clk); #1;
      checkOutput("valido_held", bus.valido, 1);
      checkOutput("no_read_in_done", bus.rd_en, 0);
    end
    bus.start = 1'b1;
    bus.readyo = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.readyo = 1'b0;
    expect_valid = 1'b0;
    checkOutput("valido_drop", bus.valido, 0);
    checkOutput("readyi_back", bus.readyi, 1);
    checkOutput("start_ignored_in_done", bus.rd_en, 0);
    @(posedge clk); #1;
  endtask

  task automatic checkReset();
    checkOutput("rst_readyi", bus.readyi, 1);
    checkOutput("rst_valido", bus.valido, 0);
    checkOutput("rst_rd_en", bus.rd_en, 0);
    checkOutput("rst_cpr_row", bus.cpr_row, 0);
    checkOutput("rst_spr_row", bus.spr_row, 0);
    checkOutput("rst_spr_off", bus.spr_off, 0);
    checkOutput("rst_mv_x", bus.mv_x, 0);
    checkOutput("rst_mv_y", bus.mv_y, 0);
    checkOutput("rst_min_sad", bus.min_sad, (64'd1 << SADW) - 1);
    checkOutput("rst_early_stop", bus.early_stop, 0);
    checkOutput("rst_cand_cnt", bus.cand_cnt, 0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    bus.start = 1'b0;
    bus.et_en = 1'b0;
    bus.sad_thresh = '0;
    bus.readyo = 1'b0;
    bus.pixel_cpr_in = '0;
    bus.pixel_spr_in = '0;
    setupIdentity(0);

    #2 rst_n = 1'b0;
    #10;
    checkReset();
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] identity match with backpressure");
    setupIdentity(0);
    applyStimulus(0, 0, 10);
    checkOutput("model_id_lat", exp_lat, 126);
    checkOutput("id_mv_x", bus.mv_x, 3);
    checkOutput("id_mv_y", bus.mv_y, 2);
    checkOutput("id_min_sad", bus.min_sad, 0);
    checkOutput("id_cand_cnt", bus.cand_cnt, 25);
    checkOutput("id_early_stop", bus.early_stop, 0);

    $display("[TB] early candidate abort");
    setupIdentity(1);
    applyStimulus(1, 0, 2);
    checkOutput("abort_faster", lat < 126, 1);
    checkOutput("abort_mv_x", bus.mv_x, 3);
    checkOutput("abort_mv_y", bus.mv_y, 2);
    checkOutput("abort_min_sad", bus.min_sad, 0);
    applyStimulus(0, 0, 0);
    checkOutput("noabort_mv_x", bus.mv_x, 3);
    checkOutput("noabort_min_sad", bus.min_sad, 0);

    $display("[TB] ties on a uniform window");
    setupUniform();
    applyStimulus(0, 0, 1);
    checkOutput("tie_mv_x", bus.mv_x, 0);
    checkOutput("tie_mv_y", bus.mv_y, 0);
    checkOutput("tie_cand_cnt", bus.cand_cnt, 25);
    applyStimulus(0, 1, 1);
    checkOutput("tie_thr_early_stop", bus.early_stop, 1);
    checkOutput("tie_thr_cand_cnt", bus.cand_cnt, 1);
    checkOutput("tie_thr_lat", lat, 6);

    $display("[TB] threshold stop");
    setupThresh();
    applyStimulus(0, 5, 3);
    checkOutput("model_thr_sad", exp_sad, 3);
    checkOutput("thr_mv_x", bus.mv_x, 1);
    checkOutput("thr_mv_y", bus.mv_y, 0);
    checkOutput("thr_min_sad", bus.min_sad, 3);
    checkOutput("thr_early_stop", bus.early_stop, 1);
    checkOutput("thr_cand_cnt", bus.cand_cnt, 2);

    $display("[TB] reset in the middle of a search");
    setupIdentity(0);
    bus.et_en = 1'b0;
    bus.sad_thresh = '0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 0;
    while (bus.cand_cnt !== 12 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("reached_cand_12", bus.cand_cnt, 12);
    #2 rst_n = 1'b0;
    #1;
    checkReset();
    @(posedge clk); #1;
    checkOutput("rst_hold_valido", bus.valido, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(0, 0, 0);
    checkOutput("post_rst_mv_x", bus.mv_x, 3);
    checkOutput("post_rst_mv_y", bus.mv_y, 2);
    checkOutput("post_rst_cand_cnt", bus.cand_cnt, 25);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/me_full_search_et.md
Name: me_full_search_et

Overview:
- Parametrised full-search integer motion-estimation engine for the inter-prediction path.
- Evaluates every candidate position of a MACRO_DIM x MACRO_DIM current macroblock inside a SEARCH_DIM x SEARCH_DIM search window.
- Streams one row pair per cycle from external CPR/SPR buffers and returns the best motion vector with its SAD.
- Over the previous ME generation it adds generic widths, partial-SAD early candidate abort, threshold-based early search stop, and a candidate-count report.

Parameters:
- MACRO_DIM, 16, macroblock edge in pixels (power of two, >=4).
- SEARCH_DIM, 32, search-window edge in pixels (> MACRO_DIM).
- RANGE (localparam), SEARCH_DIM-MACRO_DIM+1, candidate positions per axis.
- SADW (localparam), $clog2(MACRO_DIM*MACRO_DIM*255+1), SAD width (16 for MACRO_DIM=16).
- MVW (localparam), $clog2(RANGE), mv component width.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  start request; accepted when readyi=1.
- readyi  out  1  engine idle, can accept start.
- et_en  in  1  enable partial-SAD candidate abort; sampled at start.
- sad_thresh  in  SADW  early-stop threshold; sampled at start; 0 disables.
- rd_en  out  1  row read strobe to CPR/SPR buffers.
- cpr_row  out  $clog2(MACRO_DIM)  current-MB row address.
- spr_row  out  $clog2(SEARCH_DIM)  search-window row address (cand_y + row).
- spr_off  out  MVW  column offset (cand_x); external shifter aligns SPR data.
- pixel_cpr_in  in  MACRO_DIM*8  current-MB row; pixel 0 in LSBs; valid the cycle after rd_en.
- pixel_spr_in  in  MACRO_DIM*8  aligned search row; same timing as pixel_cpr_in.
- valido  out  1  result valid; held until readyo.
- readyo  in  1  consumer accepts result.
- mv_x, mv_y  out  MVW each  best candidate position, unsigned 0..RANGE-1.
- min_sad  out  SADW  SAD of best candidate.
- early_stop  out  1  search ended by the threshold.
- cand_cnt  out  $clog2(RANGE*RANGE+1)  candidates started.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: readyi=1, valido=0, rd_en=0, all addresses=0, mv_x=mv_y=0, min_sad=all-ones, early_stop=0, cand_cnt=0.
- Reset mid-search aborts immediately; no partial result is emitted.
- States and transitions:
  - IDLE: readyi=1. start=1 latches et_en and sad_thresh, clears best (valid flag=0, min=all-ones), cand_cnt=0, cand=(0,0), then goes to FILL.
  - FILL: 1 cycle. rd_en=1, row 0 of the current candidate; cand_cnt increments. Goes to ACC.
  - ACC: row r data arrives. row_sad = sum over MACRO_DIM of |cpr-spr|, all unsigned and zero-extended to SADW, no saturation. acc = (r==0 ? row_sad : acc+row_sad). If r<MACRO_DIM-1, rd_en=1 and row r+1 is issued in the same cycle.
- Candidate abort: when et_en=1, best valid, and acc >= best min after row r<MACRO_DIM-1, the candidate is discarded this cycle. The in-flight row r+1 read is ignored, and the next candidate's FILL follows.
- Candidate completion, after row MACRO_DIM-1:
  - Update best iff best invalid or acc < min. Ties keep the earlier candidate.
  - Scan order is raster: cand_x inner, cand_y outer.
- Early stop: after an update, if sad_thresh != 0 and new min <= sad_thresh, go to DONE with early_stop=1.
- Otherwise advance: x wraps at RANGE-1 to 0 and y increments. After (RANGE-1,RANGE-1), go to DONE with early_stop=0.
- Latency without aborts: RANGE*RANGE*(MACRO_DIM+1) cycles from start acceptance to DONE entry, plus 1 cycle to valido.
- An aborted candidate after row r costs r+2 cycles.
- DONE: valido=1 and outputs stable. readyo=1 the same cycle returns to IDLE (valido=0 next cycle). start while not idle is ignored.
- Simultaneous: start is not accepted in DONE even with readyo=1; readyi rises the cycle after.
- mv_x/mv_y/min_sad update only on best changes; they hold between searches.

Test Plan (MACRO_DIM=4, SEARCH_DIM=8, RANGE=5):
- Identity match: window zero except MB copy at (3,2), MB pixels 10..25, et_en=0, thresh=0 -> mv=(3,2), min_sad=0, early_stop=0, cand_cnt=25, valido exactly 125+1 cycles after start.
- Ties: uniform window and MB all 7 -> mv=(0,0), min_sad=0, cand_cnt=25; with thresh=1 -> early_stop=1, cand_cnt=1.
- Early abort: same as identity with et_en=1 and large first-row mismatch (255 vs 0) -> same mv/min_sad, total cycles < 125, no result difference.
- Threshold stop: match at (1,0) with SAD 3, thresh=5 -> stop after candidate 2, mv=(1,0), min_sad=3, early_stop=1, cand_cnt=2.
- Backpressure: readyo=0 for 10 cycles in DONE -> valido and outputs held, readyi=0, start pulses ignored; readyo=1 -> IDLE next cycle.
- Reset mid-search: rst_n low at candidate 12 -> all outputs at reset values asynchronously; a fresh start then gives the correct result.
